// File: rtl/puzzle_move_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// puzzle_move_ctrl_pkg
//   Shared definitions for the 2x3 sliding-puzzle move controller:
//   board geometry, solved-board default, blank movement directions and the
//   controller FSM state encodings.
//   No ports (package).
// ----------------------------------------------------------------------------
package puzzle_move_ctrl_pkg;

    // Board geometry: 2 rows x 3 columns, 3 bits per cell, cell 0 in the MSBs.
    localparam int unsigned CellW    = 3;
    localparam int unsigned NumCells = 6;
    localparam int unsigned NumCols  = 3;
    localparam int unsigned BoardW   = CellW * NumCells;
    localparam int unsigned DataW    = 40;

    localparam logic [BoardW-1:0] GoalDefault = 18'o123450;

    // Direction the blank moves in.
    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_e;

    // Controller FSM state encodings.
    typedef logic [2:0] state_t;
    localparam state_t StIdle  = 3'd0;
    localparam state_t StRead  = 3'd1;
    localparam state_t StCalc  = 3'd2;
    localparam state_t StWrBrd = 3'd3;
    localparam state_t StWrCnt = 3'd4;

    // Extract cell idx (row*3+col) from a packed board.
    function automatic logic [CellW-1:0] get_cell(input logic [BoardW-1:0] b,
                                                  input int unsigned idx);
        return b[BoardW - CellW * (idx + 1) +: CellW];
    endfunction

endpackage

// File: rtl/puzzle_move_calc.sv
// ----------------------------------------------------------------------------
// puzzle_move_calc
//   Purely combinational move evaluator. Finds the lowest-index blank cell,
//   decides whether the blank may move in the requested direction and, if so,
//   produces the board with the blank swapped with its neighbour.
// Ports:
//   board     in  18  current board
//   dir       in   2  blank movement direction (dir_e encoding)
//   new_board out 18  board after the move (equals board when illegal)
//   legal     out  1  move is legal
// ----------------------------------------------------------------------------
module puzzle_move_calc
    import puzzle_move_ctrl_pkg::*;
(
    input  logic [BoardW-1:0] board,
    input  logic [1:0]        dir,
    output logic [BoardW-1:0] new_board,
    output logic              legal
);

    logic       found;
    logic [2:0] blank;
    logic [2:0] nbr;
    logic       in_row1;
    logic [1:0] col;

    always_comb begin
        found = 1'b0;
        blank = '0;
        for (int unsigned i = 0; i < NumCells; i++) begin
            if (!found && get_cell(board, i) == '0) begin
                found = 1'b1;
                blank = 3'(i);
            end
        end

        in_row1 = (blank >= 3'(NumCols));
        col     = in_row1 ? 2'(blank - 3'(NumCols)) : blank[1:0];

        // A board without any blank cell can never move.
        legal = found;
        nbr   = blank;
        case (dir)
            DirUp: begin
                if (in_row1) nbr = blank - 3'(NumCols);
                else         legal = 1'b0;
            end
            DirDown: begin
                if (!in_row1) nbr = blank + 3'(NumCols);
                else          legal = 1'b0;
            end
            DirLeft: begin
                if (col != 2'd0) nbr = blank - 3'd1;
                else             legal = 1'b0;
            end
            DirRight: begin
                if (col != 2'd2) nbr = blank + 3'd1;
                else             legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase

        new_board = board;
        if (legal) begin
            for (int unsigned i = 0; i < NumCells; i++) begin
                if (3'(i) == blank) begin
                    new_board[BoardW - CellW * (i + 1) +: CellW] =
                        get_cell(board, int'(nbr));
                end else if (3'(i) == nbr) begin
                    new_board[BoardW - CellW * (i + 1) +: CellW] = '0;
                end
            end
        end
    end

endmodule

// File: rtl/puzzle_move_ctrl.sv
// ----------------------------------------------------------------------------
// puzzle_move_ctrl
//   Executes one sliding-puzzle move per command against an external register
//   file: reads the board and move count, evaluates the move, writes back the
//   new board and the incremented count, and reports done/illegal/solved.
//   Sequence from acceptance at cycle T:
//     T+1 READ, T+2 CALC, T+3 WR_BRD (or illegal pulse), T+4 WR_CNT, T+5 done.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   cmd_valid, cmd_dir   move request and blank direction
//   cmd_ready            request accepted (IDLE only)
//   rf_src0, rf_src1     fixed read addresses (board, count)
//   rf_data0, rf_data1   combinational read data
//   rf_we, rf_dst        write enable / address
//   rf_wdata             write data
//   done, illegal        one-cycle completion / rejection pulses
//   solved               last committed board equals GOAL
//   busy                 command in progress
// ----------------------------------------------------------------------------
module puzzle_move_ctrl
    import puzzle_move_ctrl_pkg::*;
#(
    parameter logic [BoardW-1:0] GOAL      = GoalDefault,
    parameter logic [3:0]        REG_BOARD = 4'd0,
    parameter logic [3:0]        REG_CNT   = 4'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_dir,
    output logic             cmd_ready,
    output logic [3:0]       rf_src0,
    output logic [3:0]       rf_src1,
    output logic [3:0]       rf_dst,
    input  logic [DataW-1:0] rf_data0,
    input  logic [DataW-1:0] rf_data1,
    output logic             rf_we,
    output logic [DataW-1:0] rf_wdata,
    output logic             done,
    output logic             illegal,
    output logic             solved,
    output logic             busy
);

    state_t            state_q, state_d;
    logic [1:0]        dir_q, dir_d;
    logic [BoardW-1:0] board_q, board_d;
    logic [DataW-1:0]  cnt_q, cnt_d;
    logic [BoardW-1:0] new_board_q, new_board_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;
    logic              solved_q, solved_d;

    logic [BoardW-1:0] calc_board;
    logic              calc_legal;

    // Upper board-register bits carry no information.
    logic unused_board_hi;
    assign unused_board_hi = ^rf_data0[DataW-1:BoardW];

    puzzle_move_calc u_calc (
        .board     (board_q),
        .dir       (dir_q),
        .new_board (calc_board),
        .legal     (calc_legal)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        board_d     = board_q;
        cnt_d       = cnt_q;
        new_board_d = new_board_q;
        solved_d    = solved_q;
        done_d      = 1'b0;
        illegal_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    state_d = StRead;
                end
            end
            StRead: begin
                board_d = rf_data0[BoardW-1:0];
                cnt_d   = rf_data1;
                state_d = StCalc;
            end
            StCalc: begin
                if (calc_legal) begin
                    new_board_d = calc_board;
                    state_d     = StWrBrd;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWrBrd: begin
                solved_d = (new_board_q == GOAL);
                state_d  = StWrCnt;
            end
            StWrCnt: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dir_q       <= '0;
            board_q     <= '0;
            cnt_q       <= '0;
            new_board_q <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            // Matches the register file's reset board.
            solved_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            board_q     <= board_d;
            cnt_q       <= cnt_d;
            new_board_q <= new_board_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            solved_q    <= solved_d;
        end
    end

    // Outputs are gated by rst_n so a reset asserted mid-write blocks the
    // write in that very cycle.
    always_comb begin
        rf_src0  = REG_BOARD;
        rf_src1  = REG_CNT;
        rf_we    = 1'b0;
        rf_dst   = REG_BOARD;
        rf_wdata = '0;
        if (rst_n) begin
            case (state_q)
                StWrBrd: begin
                    rf_we    = 1'b1;
                    rf_dst   = REG_BOARD;
                    rf_wdata = {{(DataW - BoardW){1'b0}}, new_board_q};
                end
                StWrCnt: begin
                    rf_we    = 1'b1;
                    rf_dst   = REG_CNT;
                    rf_wdata = cnt_q + 40'd1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = rst_n && (state_q == StIdle);
    assign busy      = rst_n && (state_q != StIdle);
    assign done      = rst_n && done_q;
    assign illegal   = rst_n && illegal_q;
    assign solved    = solved_q;

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
module tb_puzzle_move_ctrl;
    import puzzle_move_ctrl_pkg::*;

    localparam logic [17:0] Goal     = 18'o123450;
    localparam logic [3:0]  RegBoard = 4'd0;
    localparam logic [3:0]  RegCnt   = 4'd1;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic        cmd_ready;
    logic [3:0]  rf_src0, rf_src1, rf_dst;
    logic [39:0] rf_data0, rf_data1;
    logic        rf_we;
    logic [39:0] rf_wdata;
    logic        done, illegal, solved, busy;

    logic [39:0] rf [16];

    puzzle_move_ctrl #(
        .GOAL      (Goal),
        .REG_BOARD (RegBoard),
        .REG_CNT   (RegCnt)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_ready (cmd_ready),
        .rf_src0   (rf_src0),
        .rf_src1   (rf_src1),
        .rf_dst    (rf_dst),
        .rf_data0  (rf_data0),
        .rf_data1  (rf_data1),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .done      (done),
        .illegal   (illegal),
        .solved    (solved),
        .busy      (busy)
    );

    assign rf_data0 = rf[rf_src0];
    assign rf_data1 = rf[rf_src1];

    always @(posedge clk) if (rf_we) rf[rf_dst] <= rf_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: board as a list of cells, blank found by search.
    logic [17:0] m_board;
    logic [39:0] m_cnt;
    bit          m_solved;

    function automatic void model_move(input logic [17:0] b, input logic [1:0] d,
                                       output bit legal, output logic [17:0] nb);
        int c[6];
        int blank = -1;
        int tgt = 0;
        int r, col, tmp;
        for (int i = 0; i < 6; i++) c[i] = int'((b >> (15 - 3 * i)) & 18'd7);
        for (int i = 0; i < 6; i++) if (c[i] == 0 && blank < 0) blank = i;
        legal = (blank >= 0);
        if (legal) begin
            r   = blank / 3;
            col = blank % 3;
            case (d)
                2'd0: begin legal = (r == 1);   tgt = blank - 3; end
                2'd1: begin legal = (r == 0);   tgt = blank + 3; end
                2'd2: begin legal = (col > 0);  tgt = blank - 1; end
                default: begin legal = (col < 2); tgt = blank + 1; end
            endcase
        end
        if (legal) begin
            tmp = c[blank]; c[blank] = c[tgt]; c[tgt] = tmp;
        end
        nb = '0;
        for (int i = 0; i < 6; i++) nb = nb | (18'(c[i]) << (15 - 3 * i));
    endfunction

    typedef struct {
        bit          legal;
        logic [17:0] board;
        logic [39:0] cnt;
        bit          solved;
        int          t;
    } exp_t;

    typedef struct {
        logic [3:0]  dst;
        logic [39:0] data;
        int          t;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_l[$];

    // Called at the negedge of the acceptance cycle.
    task automatic accept(input logic [1:0] d);
        exp_t        e;
        bit          lg;
        logic [17:0] nb;
        model_move(m_board, d, lg, nb);
        if (lg) begin
            m_board  = nb;
            m_cnt    = m_cnt + 40'd1;
            m_solved = (nb == Goal);
        end
        e.legal  = lg;
        e.board  = m_board;
        e.cnt    = m_cnt;
        e.solved = m_solved;
        e.t      = cyc;
        exp_q.push_back(e);
    endtask

    // Monitor: collects writes, pops the scoreboard on each done/illegal pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            wr_l.delete();
        end else begin
            chk("rf_src0", 64'(rf_src0), 64'(RegBoard));
            chk("rf_src1", 64'(rf_src1), 64'(RegCnt));
            if (rf_we) begin
                if (exp_q.size() == 0) chk("stray_write", 64'(rf_we), 64'd0);
                wr_l.push_back('{rf_dst, rf_wdata, cyc});
            end
            if (done || illegal) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, done, illegal}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", {62'd0, done, illegal}, {62'd0, e.legal, !e.legal});
                    chk("latency", 64'(cyc - e.t), e.legal ? 64'd5 : 64'd3);
                    chk("solved", 64'(solved), 64'(e.solved));
                    if (e.legal) begin
                        chk("num_writes", 64'(wr_l.size()), 64'd2);
                        if (wr_l.size() == 2) begin
                            chk("brd_dst", 64'(wr_l[0].dst), 64'(RegBoard));
                            chk("brd_data", 64'(wr_l[0].data), 64'(e.board));
                            chk("brd_time", 64'(wr_l[0].t - e.t), 64'd3);
                            chk("cnt_dst", 64'(wr_l[1].dst), 64'(RegCnt));
                            chk("cnt_data", 64'(wr_l[1].data), 64'(e.cnt));
                            chk("cnt_time", 64'(wr_l[1].t - e.t), 64'd4);
                        end
                    end else begin
                        chk("num_writes", 64'(wr_l.size()), 64'd0);
                    end
                    wr_l.delete();
                end
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 2'd0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) rf[i] = '0;
        rf[RegBoard] = {22'd0, Goal};
        m_board  = Goal;
        m_cnt    = '0;
        m_solved = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_pulses", {62'd0, done, illegal}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_solved", 64'(solved), 64'd1);
    endtask

    task automatic issue(input logic [1:0] d);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 64'(cmd_ready), 64'd1);
        end else begin
            cmd_valid = 1'b1;
            cmd_dir   = d;
            accept(d);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] b;
        int          p[6];
        int          k, tmp;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 2'd0;

        // LEFT from the solved board.
        do_reset();
        issue(2'd2);
        drain();
        chk("left_board", 64'(rf[RegBoard]), 64'(18'o123405));
        chk("left_cnt", 64'(rf[RegCnt]), 64'd1);
        chk("left_solved", 64'(solved), 64'd0);

        // UP from the solved board.
        do_reset();
        issue(2'd0);
        drain();
        chk("up_board", 64'(rf[RegBoard]), 64'(18'o120453));
        chk("up_cnt", 64'(rf[RegCnt]), 64'd1);

        // DOWN with the blank in row 1 is rejected.
        do_reset();
        issue(2'd1);
        drain();
        chk("down_board", 64'(rf[RegBoard]), 64'(Goal));
        chk("down_cnt", 64'(rf[RegCnt]), 64'd0);
        chk("down_solved", 64'(solved), 64'd1);

        // LEFT then RIGHT, second accepted in the done cycle.
        do_reset();
        issue(2'd2);
        issue(2'd3);
        drain();
        chk("lr_board", 64'(rf[RegBoard]), 64'(Goal));
        chk("lr_cnt", 64'(rf[RegCnt]), 64'd2);
        chk("lr_solved", 64'(solved), 64'd1);

        // Count wraps from all-ones.
        do_reset();
        rf[RegCnt] = 40'hFF_FFFF_FFFF;
        m_cnt      = 40'hFF_FFFF_FFFF;
        issue(2'd0);
        drain();
        chk("wrap_cnt", 64'(rf[RegCnt]), 64'd0);

        // Reset asserted during WR_BRD.
        do_reset();
        issue(2'd2);
        @(negedge clk);
        @(negedge clk);
        chk("wrbrd_we", 64'(rf_we), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_we", 64'(rf_we), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_board", 64'(rf[RegBoard]), 64'(Goal));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_idle", {62'd0, cmd_ready, busy}, 64'd2);
        repeat (8) @(negedge clk);
        chk("midrst_cnt", 64'(rf[RegCnt]), 64'd0);

        // Randomised moves, board/count preloads and ignored busy requests.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_ready && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    b = 18'($urandom);
                end else begin
                    for (int i = 0; i < 6; i++) p[i] = i;
                    for (int i = 5; i > 0; i--) begin
                        k = int'($urandom_range(0, i));
                        tmp = p[i]; p[i] = p[k]; p[k] = tmp;
                    end
                    b = '0;
                    for (int i = 0; i < 6; i++) b = b | (18'(p[i]) << (15 - 3 * i));
                end
                rf[RegBoard] = {22'($urandom), b};
                m_board      = b;
                if ($urandom_range(0, 3) == 0) begin
                    rf[RegCnt] = {8'($urandom), 32'($urandom)} | 40'hFF_FFFF_FFF0;
                    m_cnt      = rf[RegCnt];
                end
            end
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_dir   = 2'($urandom);
            if (cmd_valid && cmd_ready) accept(cmd_dir);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        drain();
        chk("rand_board", 64'(rf[RegBoard][17:0]), 64'(m_board));
        chk("rand_cnt", 64'(rf[RegCnt]), 64'(m_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puzzle_move_ctrl.md
PUZZLE_MOVE_CTRL -- requirements
Module: puzzle_move_ctrl

Interface
REQ-001 Parameter GOAL, default 18'o123450, solved board encoding.
REQ-002 Parameter REG_BOARD, default 4'd0, register index holding the board.
REQ-003 Parameter REG_CNT, default 4'd1, register index holding the move count.
REQ-004 Port clk  in  1  clock, all state updates on rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port cmd_valid  in  1  move request.
REQ-007 Port cmd_dir  in  2  blank movement: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
REQ-008 Port cmd_ready  out  1  high only in IDLE.
REQ-009 Port rf_src0, rf_src1, rf_dst  out  4 each  register file addresses.
REQ-010 Port rf_data0, rf_data1  in  40 each  register file combinational read data.
REQ-011 Port rf_we  out  1  register file write enable.
REQ-012 Port rf_wdata  out  40  register file write data.
REQ-013 Port done  out  1  one-cycle pulse: legal move committed.
REQ-014 Port illegal  out  1  one-cycle pulse: move rejected, no write performed.
REQ-015 Port solved  out  1  last committed board equals GOAL.
REQ-016 Port busy  out  1  high when not IDLE.

Function
REQ-017 Board layout: 2 rows x 3 cols; cell i = row*3+col occupies bits [17-3i:15-3i]; value 0 = blank; bits 39:18 are ignored on read and written as 0.
REQ-018 rf_src0 SHALL be REG_BOARD and rf_src1 SHALL be REG_CNT at all times.
REQ-019 FSM states: IDLE, READ, CALC, WR_BRD, WR_CNT.
REQ-020 IDLE -> READ on cmd_valid & cmd_ready (cycle T); cmd_dir is latched at T.
REQ-021 READ (T+1) SHALL capture rf_data0[17:0] and rf_data1 into internal registers; -> CALC.
REQ-022 CALC (T+2) SHALL locate the lowest-index blank cell and evaluate legality.
REQ-023 A move is illegal when no cell is 0, or UP with the blank in row 0, DOWN in row 1, LEFT in col 0, or RIGHT in col 2.
REQ-024 Illegal: CALC -> IDLE; illegal = 1 at T+3 only; rf_we stays 0 for the whole command.
REQ-025 Legal: swap the blank with the neighbour in cmd_dir (UP -3, DOWN +3, LEFT -1, RIGHT +1); CALC -> WR_BRD.
REQ-026 WR_BRD (T+3): rf_we = 1, rf_dst = REG_BOARD, rf_wdata = {22'b0, new board}; -> WR_CNT.
REQ-027 WR_CNT (T+4): rf_we = 1, rf_dst = REG_CNT, rf_wdata = captured count + 1, modulo 2^40 (all-ones wraps to 0); -> IDLE.
REQ-028 done = 1 at T+5 only; a new command may be accepted in that same cycle.
REQ-029 solved SHALL update at T+4 to (new board == GOAL); rejected moves leave it unchanged.
REQ-030 Outside WR_BRD/WR_CNT: rf_we = 0, rf_dst = REG_BOARD, rf_wdata = 0.
REQ-031 cmd_valid while busy SHALL be ignored (no queueing).

Reset
REQ-032 While rst_n = 0: state SHALL be IDLE next cycle, rf_we = 0 combinationally (also mid-write), done = 0, illegal = 0, busy = 0, cmd_ready = 0.
REQ-033 solved SHALL reset to 1, matching the register file's reset board.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the direction encoding, board field width (3), cell count (6) and GOAL default.
REQ-035 One sub-module puzzle_move_calc (combinational: board, dir -> new board, legal) is natural; the rest is a single FSM.

Verification
REQ-036 Reset, then LEFT -> WR_BRD writes 18'o123405, WR_CNT writes 1, done at T+5, solved = 0.
REQ-037 Reset, then UP -> board 18'o120453, count 1.
REQ-038 Reset, then DOWN -> illegal at T+3, rf_we never 1, count stays 0, solved stays 1.
REQ-039 LEFT then RIGHT back-to-back (second issued at done) -> board 18'o123450, count 2, solved = 1.
REQ-040 Count preloaded to 40'hFF_FFFF_FFFF, legal move -> count written 0.
REQ-041 rst_n low during WR_BRD -> rf_we = 0 that cycle, IDLE next, no done.
